proc_run_ctrl: RTL and testbench

Run controller for the 11-bit processor. It streams a program from a host into instruction memory and holds the processor in reset while loading. It then releases the processor, counts executed cycles, detects the halt idiom (a jump to itself) and re-asserts processor reset. It sits between the host/testbench, the instruction-memory write port and the `processor` reset/PC/Instr pins.

---
 rtl/proc_run_ctrl.sv | 168 ++++++++++++++++
 tb/tb_proc_run_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_run_ctrl.sv
// Run controller: streams a host program into instruction memory, runs the processor,
// detects the jump-to-self halt idiom and counts run cycles. Watchdog: RUN_CTRL_TIMEOUT_EN.
module proc_run_ctrl #(
    parameter int CYCLE_W = 16
`ifdef RUN_CTRL_TIMEOUT_EN
    , parameter int MAX_CYCLES = 1000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_valid,
    input  logic [10:0]        ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    input  logic               start,
    input  logic               abort,
    output logic               imem_we,
    output logic [7:0]         imem_addr,
    output logic [10:0]        imem_wdata,
    output logic               cpu_reset,
    input  logic [7:0]         cpu_pc,
    input  logic [10:0]        cpu_instr,
    output logic               busy,
    output logic               done,
    output logic               load_err,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [7:0]         wr_ptr_q, wr_ptr_d;
    logic               load_err_q, load_err_d;
    logic [CYCLE_W-1:0] cycle_count_q, cycle_count_d;
    logic               cpu_reset_q;

    logic               accept;
    logic               halt_seen;
    logic               wd_fire;
    logic               start_req;
    logic [CYCLE_W-1:0] cnt_inc;
    logic               instr_unused;

    assign ld_ready   = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept     = ld_valid & ld_ready;
    assign imem_we    = accept;
    assign imem_addr  = wr_ptr_q;
    assign imem_wdata = ld_data;

    // Halt idiom: a jump whose target equals the address it was fetched from.
    assign halt_seen    = (cpu_instr[10:8] == 3'b101) && ({cpu_instr[6:0], 1'b0} == cpu_pc);
    assign instr_unused = cpu_instr[7];

    assign cnt_inc   = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CYCLE_W'(1);
    assign start_req = ((state_q == ST_READY) || (state_q == ST_HALT)) && !ld_valid && start;

`ifdef RUN_CTRL_TIMEOUT_EN
    logic timeout_q, timeout_d;

    assign wd_fire = (cnt_inc == CYCLE_W'(MAX_CYCLES));

    always_comb begin
        timeout_d = timeout_q;
        if (!abort) begin
            if (start_req) begin
                timeout_d = 1'b0;
            end else if ((state_q == ST_RUN) && !halt_seen && wd_fire) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        load_err_d    = load_err_q;
        cycle_count_d = cycle_count_q;
        if (abort) begin
            state_d  = ST_IDLE;
            wr_ptr_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        wr_ptr_d   = 8'd1;
                        load_err_d = 1'b0;
                        state_d    = ld_last ? ST_READY : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        // The pointer parks at the last address instead of wrapping.
                        if (wr_ptr_q != 8'hFF) begin
                            wr_ptr_d = wr_ptr_q + 8'd1;
                        end
                        if (ld_last) begin
                            state_d = ST_READY;
                        end else if (wr_ptr_q == 8'hFF) begin
                            state_d    = ST_READY;
                            load_err_d = 1'b1;
                        end
                    end
                end
                ST_READY, ST_HALT: begin
                    if (ld_valid) begin
                        state_d  = ST_IDLE;
                        wr_ptr_d = 8'd0;
                    end else if (start) begin
                        state_d       = ST_RUN;
                        cycle_count_d = '0;
                    end
                end
                ST_RUN: begin
                    cycle_count_d = cnt_inc;
                    if (halt_seen || wd_fire) begin
                        state_d = ST_HALT;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= 8'd0;
            load_err_q    <= 1'b0;
            cycle_count_q <= '0;
            cpu_reset_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            load_err_q    <= load_err_d;
            cycle_count_q <= cycle_count_d;
            cpu_reset_q   <= (state_d != ST_RUN);
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done        = (state_q == ST_HALT);
    assign load_err    = load_err_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: a toy processor executes the loaded image while
// expected writes and run outcomes are queued from a program-level model.
module tb_proc_run_ctrl;
    localparam int CW = 16;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam int MAXC = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_last, ld_ready, start, abort;
    logic [10:0]   ld_data;
    logic          imem_we;
    logic [7:0]    imem_addr;
    logic [10:0]   imem_wdata;
    logic          cpu_reset;
    logic [7:0]    cpu_pc;
    logic [10:0]   cpu_instr;
    logic          busy, done, load_err, timeout;
    logic [CW-1:0] cycle_count;

    proc_run_ctrl #(
        .CYCLE_W(CW)
`ifdef RUN_CTRL_TIMEOUT_EN
        , .MAX_CYCLES(MAXC)
`endif
    ) dut (
        .clk(clk), .reset(rst),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .start(start), .abort(abort),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .busy(busy), .done(done), .load_err(load_err), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Environment: instruction memory written by the DUT, and a processor that
    // steps PC by one or follows a jump (opcode 101, target {imm7,0}).
    logic [10:0] imem_tb [256];
    always @(posedge clk) begin
        if (imem_we) imem_tb[imem_addr] <= imem_wdata;
    end
    assign cpu_instr = imem_tb[cpu_pc];
    always @(posedge clk) begin
        if (cpu_reset) cpu_pc <= 8'd0;
        else if (cpu_instr[10:8] == 3'b101) cpu_pc <= {cpu_instr[6:0], 1'b0};
        else cpu_pc <= cpu_pc + 8'd1;
    end

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int count; int to; int dn; } run_t;
    wr_t  wr_q[$];
    run_t run_q[$];
    logic [10:0] prog [256];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the intended program image until the self-jump (or watchdog).
    function automatic run_t exp_run();
        run_t r;
        int pc = 0;
        logic [10:0] w;
        r.count = 0; r.to = 0; r.dn = 1;
        for (int c = 1; c <= 5000; c++) begin
            w = prog[pc];
            if (w[10:8] == 3'b101 && int'({w[6:0], 1'b0}) == pc) begin
                r.count = c;
                return r;
            end
`ifdef RUN_CTRL_TIMEOUT_EN
            if (c == MAXC) begin
                r.count = c; r.to = 1;
                return r;
            end
`endif
            pc = (w[10:8] == 3'b101) ? int'({w[6:0], 1'b0}) : (pc + 1) % 256;
        end
        return r;
    endfunction

    // Monitor: pops expectations whenever the DUT writes memory or ends a run.
    logic prev_cpu_reset = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write_addr", int'(imem_addr), -1);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    $display("write addr=%0d data=%03h", imem_addr, imem_wdata);
                    chk("write_addr", int'(imem_addr), e.addr);
                    chk("write_data", int'(imem_wdata), e.data);
                end
            end
            if (cpu_reset && !prev_cpu_reset) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_run_end", int'(cycle_count), -1);
                end else begin
                    run_t e;
                    e = run_q.pop_front();
                    $display("run end cycles=%0d timeout=%0d done=%0d", cycle_count, timeout, done);
                    chk("run_cycles", int'(cycle_count), e.count);
                    chk("run_timeout", int'(timeout), e.to);
                    chk("run_done", int'(done), e.dn);
                end
            end
        end
        prev_cpu_reset <= cpu_reset;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_prog(input int n, input bit jumps, input bit end_halt);
        logic [10:0] w;
        int t;
        for (int i = 0; i < n; i++) begin
            w = 11'($urandom_range(0, 2047));
            if (w[10:8] == 3'b101) w[10:8] = 3'b000;
            if (jumps && i + 3 < n && $urandom_range(0, 5) == 0) begin
                t = i + 1 + int'($urandom_range(0, n - 2 - i));
                if (t % 2 == 1) t++;
                w = {3'b101, 1'($urandom_range(0, 1)), 7'(t / 2)};
            end
            prog[i] = w;
        end
        if (end_halt) prog[n-1] = {3'b101, 1'($urandom_range(0, 1)), 7'((n - 1) / 2)};
    endtask

    task automatic load_words(input int n, input bit with_last, input bit from_ready);
        if (from_ready) begin
            ld_valid = 1'b1; ld_data = prog[0]; ld_last = 1'b0;
            step();
        end
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = with_last && (i == n - 1);
            if (i < 256) wr_q.push_back('{i, int'(prog[i])});
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic run_prog();
        run_q.push_back(exp_run());
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3000 && !cpu_reset; k++) step();
        chk("run_finished", int'(cpu_reset), 1);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset", int'(cpu_reset), 1);
        chk("rst_ld_ready", int'(ld_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_load_err", int'(load_err), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_cycle_count", int'(cycle_count), 0);
        ld_valid = 1'b1;
        #1 chk("rst_imem_we_hi", int'(imem_we), 1);
        ld_valid = 1'b0;
        #1 chk("rst_imem_we_lo", int'(imem_we), 0);
        rst = 1'b0;
        step();

        // Directed three-word load ending at READY.
        prog[0] = 11'h6C1; prog[1] = 11'h011; prog[2] = 11'h500;
        load_words(3, 1'b1, 1'b0);
        chk("ready_load_err", int'(load_err), 0);
        chk("ready_cpu_reset", int'(cpu_reset), 1);
        chk("ready_busy", int'(busy), 0);
        chk("ready_ld_ready", int'(ld_ready), 0);

        // Halt at PC 2 after three run cycles, then repeat from HALT.
        prog[2] = 11'h501;
        load_words(3, 1'b1, 1'b1);
        run_prog();
        run_prog();

        // Random programs with forward jumps.
        for (int it = 0; it < 8; it++) begin
            n = 2 * int'($urandom_range(0, 20)) + 1;
            gen_prog(n, 1'b1, 1'b1);
            load_words(n, 1'b1, 1'b1);
            run_prog();
        end

        // Abort mid-run at cycle_count 5.
        gen_prog(21, 1'b0, 1'b1);
        load_words(21, 1'b1, 1'b1);
        run_q.push_back('{5, 0, 0});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cycle_count == CW'(5)) break;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_cpu_reset", int'(cpu_reset), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ld_ready", int'(ld_ready), 1);
        chk("abort_cycle_count", int'(cycle_count), 5);
        step();

        // Overflow: 256 writes, then READY with load_err; word 257 not accepted.
        gen_prog(256, 1'b0, 1'b0);
        load_words(256, 1'b0, 1'b0);
        chk("ovf_load_err", int'(load_err), 1);
        chk("ovf_busy", int'(busy), 0);
        chk("ovf_ld_ready", int'(ld_ready), 0);
        ld_valid = 1'b1; ld_data = 11'h123;
        step();
        ld_valid = 1'b0;
        chk("ovf_word257_idle", int'(ld_ready), 1);
        chk("ovf_err_held", int'(load_err), 1);

        // New load clears load_err.
        gen_prog(5, 1'b1, 1'b1);
        load_words(5, 1'b1, 1'b0);
        chk("reload_load_err", int'(load_err), 0);
        run_prog();

        // In HALT, ld_valid beats start; held ld_valid then writes address 0.
        ld_valid = 1'b1; start = 1'b1; ld_data = 11'h500; ld_last = 1'b0;
        step();
        start = 1'b0;
        chk("halt_ldv_cpu_reset", int'(cpu_reset), 1);
        chk("halt_ldv_ready", int'(ld_ready), 1);
        chk("halt_ldv_done", int'(done), 0);
        prog[0] = 11'h500;
        load_words(1, 1'b1, 1'b0);
        run_prog();

`ifdef RUN_CTRL_TIMEOUT_EN
        // Watchdog with no halt, then a halt coinciding with the watchdog limit.
        gen_prog(30, 1'b0, 1'b0);
        load_words(30, 1'b1, 1'b1);
        run_prog();
        for (int i = 0; i < 8; i++) prog[i] = 11'h011;
        prog[8] = {3'b101, 1'b0, 7'd5};
        prog[9] = 11'h011;
        prog[10] = {3'b101, 1'b0, 7'd5};
        load_words(11, 1'b1, 1'b1);
        run_prog();
`endif

        repeat (3) step();
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("run_queue_drained", run_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
